// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// master = client + transmitter side, slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 grant_active;
    logic [IDW-1:0]       grant_id;
    logic                 err_timeout;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant_active, grant_id, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin scheduler sharing one 8N2 UART transmitter
// among NUM_REQ byte-stream requesters.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDW         = 2,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GAP
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic           gact_q, gact_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic           last_q, last_d;
    logic           start_q, start_d;
    logic [7:0]     data_q, data_d;
    logic           err_q, err_d;

    logic [NUM_REQ-1:0] rot;
    logic [IDW:0]       off, sum;
    logic               pick_any;
    logic [IDW-1:0]     pick_id;
    logic [IDW-1:0]     rr_next;
    logic               accept, ack_expired, gap_done;

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        rot      = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
        pick_any = |rot;
        off      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = (IDW+1)'(k);
        end
        sum = {1'b0, rr_ptr_q} + off;
        if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
        pick_id = sum[IDW-1:0];
    end

    assign rr_next     = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
    assign accept      = (state_q == S_START) && bus.req_valid[gid_q] && !bus.tx_busy;
    assign ack_expired = (cnt_q == TW'(ACK_TIMEOUT - 1));
    assign gap_done    = (cnt_q == TW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pick_any) state_d = S_START;
            S_START:     if (accept) state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (bus.tx_busy)      state_d = S_WAIT_DONE;
                else if (ack_expired) state_d = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (!last_q)             state_d = S_START;
                    else if (GAP_CYCLES > 0) state_d = S_GAP;
                    else                     state_d = S_IDLE;
                end
            end
            S_GAP:       if (gap_done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        gact_d   = gact_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        data_d   = data_q;
        start_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    gid_d  = pick_id;
                    gact_d = 1'b1;
                end
            end
            S_START: begin
                if (accept) begin
                    start_d = 1'b1;
                    data_d  = bus.req_data[{gid_q, 3'b000} +: 8];
                    last_d  = bus.req_last[gid_q];
                    cnt_d   = '0;
                end
            end
            S_WAIT_ACK: begin
                if (!bus.tx_busy) begin
                    cnt_d = cnt_q + 1'b1;
                    // Transmitter never acknowledged: abandon the packet.
                    if (ack_expired) begin
                        err_d    = 1'b1;
                        rr_ptr_d = rr_next;
                        gact_d   = 1'b0;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy && last_q) begin
                    rr_ptr_d = rr_next;
                    gact_d   = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_GAP:   cnt_d = cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            gid_q    <= '0;
            gact_q   <= 1'b0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            gact_q   <= gact_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            start_q  <= start_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready    = accept ? (NUM_REQ'(1) << gid_q) : '0;
    assign bus.tx_start     = start_q;
    assign bus.tx_data      = data_q;
    assign bus.grant_active = gact_q;
    assign bus.grant_id     = gid_q;
    assign bus.err_timeout  = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one async_transmitter (8N2 TX) among NUM_REQ byte-stream requesters. Packet-locked: once a requester is granted, its bytes go out back-to-back until it marks the last byte. The block then inserts an optional idle gap and re-arbitrates. It sits between client logic (e.g. debug/status streams) and the transmitter's TxD_start/TxD_data/TxD_busy interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
IDW, 2, grant index width, must satisfy 2^IDW >= NUM_REQ
GAP_CYCLES, 0, idle clocks inserted after each packet (0 = none)
ACK_TIMEOUT, 15, clocks to wait for tx_busy to rise after tx_start (must be at least 1)
TW, 4, width of the timeout and gap counters; must hold max(GAP_CYCLES, ACK_TIMEOUT)

Ports:
clk  in  1  system clock (one clock domain)
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i has a byte on req_data slice i
req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i]
req_last  in  NUM_REQ  byte of requester i is the final byte of its packet
req_ready  out  NUM_REQ  byte accepted this cycle (combinational, one-hot or zero)
tx_start  out  1  to transmitter TxD_start, one-cycle pulse
tx_data  out  8  to transmitter TxD_data
tx_busy  in  1  from transmitter TxD_busy
grant_active  out  1  a packet currently owns the transmitter
grant_id  out  IDW  index of the owner, valid while grant_active
err_timeout  out  1  one-cycle pulse: tx_busy did not rise within ACK_TIMEOUT

Behaviour:
- Reset (async assert, sync-released state): all outputs 0, FSM=IDLE, rr_ptr=0, counters=0, last flag=0.
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: if any req_valid is high, pick the first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Register grant_id, set grant_active=1, go to START. With no req_valid, stay in IDLE.
- START: accept only when req_valid[grant_id]=1 and tx_busy=0.
  - On accept: req_ready[grant_id]=1 for that cycle only. Next cycle: tx_data <= the byte, tx_start=1 (exactly one cycle), last flag <= req_last[grant_id], timeout counter cleared. Go to WAIT_ACK.
  - Otherwise hold START and the grant. A stalled owner blocks the others indefinitely; this is intentional packet lock.
- WAIT_ACK: on tx_busy=1, go to WAIT_DONE.
  - The counter increments per cycle. When it reaches ACK_TIMEOUT with tx_busy still 0: pulse err_timeout, drop the rest of the packet, rr_ptr <= grant_id+1 (wrap), grant_active=0, go to IDLE.
- WAIT_DONE: on tx_busy=0, go to START if last flag=0. Otherwise end the packet: rr_ptr <= grant_id+1 (wrap), grant_active=0, then go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES clocks, then go to IDLE. No req_ready is asserted.
- Latency: from req_valid rising in IDLE, req_ready fires 1 cycle later (START) and tx_start 2 cycles later.
- tx_data holds its value until the next accept. req_ready is never asserted outside START, and never to a non-owner.
- Simultaneous requests: resolved by round-robin only; no fixed priority apart from rr_ptr=0 after reset.
- req_last on the first byte gives a single-byte packet.
- Reset mid-frame: tx_start drops immediately. The transmitter finishes its frame on its own; START waits for tx_busy=0 before issuing again.
- grant_id keeps its last value while grant_active=0.

Test Plan:
- Single requester, NUM_REQ=4: req0 sends 0x55,0xA3 (last on 0xA3). Required: tx_data 0x55 then 0xA3; one tx_start per byte; tx_start only while tx_busy=0; grant_active drops after the second frame.
- Contention: req0..req3 each valid with 1-byte packets 0x10..0x13 from the same cycle after reset. Required grant order 0,1,2,3. A second round with all valid again starts at 0, since rr_ptr wraps.
- Packet lock: req1 sends a 3-byte packet while req0 is valid throughout. Required: no req_ready[0] until req1's third byte frame completes, then grant_id=0.
- Stalled owner: req2 drops req_valid after byte 1 (not last) for 50 cycles, then sends last=0x7E. Required: grant held throughout, 0x7E transmitted, no other grant in between.
- Timeout: tie tx_busy=0, ACK_TIMEOUT=15. Required: err_timeout pulses exactly once, 15 cycles after tx_start; FSM returns to IDLE; next grant goes to grant_id+1.
- GAP_CYCLES=5 plus reset: after a packet, required ≥5 idle cycles before the next grant_active. Asserting rst_n=0 during WAIT_DONE must clear all outputs asynchronously, and no tx_start may follow until tx_busy=0.
